// File: rtl/frame_path_sequencer_if.sv
// Pixel strobe, mode request and path-control bundle between the video
// front end and frame_path_sequencer.
interface frame_path_sequencer_if;
  logic       valid;
  logic [1:0] mode_req;
  logic       mode_req_en;
  logic       pass_valid;
  logic [9:0] rowcount;
  logic [9:0] colcount;
  logic       line_end;
  logic       frame_end;
  logic [1:0] mode_active;
  logic       sel_bypass;
  logic       sel_window;
  logic       path_reset;
  logic       busy;
  logic       mode_err;

  modport master (
    output valid, mode_req, mode_req_en,
    input  pass_valid, rowcount, colcount, line_end, frame_end,
    input  mode_active, sel_bypass, sel_window, path_reset, busy, mode_err
  );

  modport slave (
    input  valid, mode_req, mode_req_en,
    output pass_valid, rowcount, colcount, line_end, frame_end,
    output mode_active, sel_bypass, sel_window, path_reset, busy, mode_err
  );
endinterface

// File: rtl/frame_path_sequencer.sv
// Tracks pixel position, selects the video path mode and switches modes only
// at frame boundaries, flushing the path and blanking until a clean frame.
module frame_path_sequencer #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int DRAIN_CYCLES = 16,
  parameter int MODE_RESET   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  frame_path_sequencer_if.slave bus
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_SYNC    = 2'd3;

  localparam int              DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [9:0]      COL_LAST   = 10'(WIDTH - 1);
  localparam logic [9:0]      ROW_LAST   = 10'(HEIGHT - 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [1:0]      MODE_INIT  = 2'(MODE_RESET);

  logic [1:0]    state_q, state_d;
  logic [9:0]    col_q, col_d;
  logic [9:0]    row_q, row_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    pend_q, pend_d;
  logic [DW-1:0] drain_q, drain_d;

  logic          pass_valid_q, pass_valid_d;
  logic [9:0]    rowcount_q, rowcount_d;
  logic [9:0]    colcount_q, colcount_d;
  logic          line_end_q, line_end_d;
  logic          frame_end_q, frame_end_d;
  logic          mode_err_q, mode_err_d;

  logic line_last;
  logic wrap_frame;
  logic req_legal;
  logic pass_en;

  assign line_last  = bus.valid && (col_q == COL_LAST);
  assign wrap_frame = line_last && (row_q == ROW_LAST);
  assign req_legal  = bus.mode_req_en && (bus.mode_req != 2'd3);
  assign pass_en    = (state_q == ST_RUN) || (state_q == ST_PENDING);

  // Position keeps counting in every state so frame alignment survives a switch.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (bus.valid) begin
      if (col_q == COL_LAST) begin
        col_d = 10'd0;
        row_d = (row_q == ROW_LAST) ? 10'd0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        if (req_legal && (bus.mode_req != mode_q)) begin
          pend_d  = bus.mode_req;
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        // A request back to the active mode cancels, even on the frame wrap.
        if (req_legal && (bus.mode_req == mode_q)) begin
          state_d = ST_RUN;
        end else begin
          if (req_legal) begin
            pend_d = bus.mode_req;
          end
          if (wrap_frame) begin
            mode_d  = req_legal ? bus.mode_req : pend_q;
            drain_d = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_SYNC;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      ST_SYNC: begin
        if (wrap_frame) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pass_valid_d = bus.valid && pass_en;
    rowcount_d   = row_q;
    colcount_d   = col_q;
    line_end_d   = line_last;
    frame_end_d  = wrap_frame;
    mode_err_d   = bus.mode_req_en && (bus.mode_req == 2'd3);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      col_q        <= 10'd0;
      row_q        <= 10'd0;
      mode_q       <= MODE_INIT;
      pend_q       <= 2'd0;
      drain_q      <= '0;
      pass_valid_q <= 1'b0;
      rowcount_q   <= 10'd0;
      colcount_q   <= 10'd0;
      line_end_q   <= 1'b0;
      frame_end_q  <= 1'b0;
      mode_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      mode_q       <= mode_d;
      pend_q       <= pend_d;
      drain_q      <= drain_d;
      pass_valid_q <= pass_valid_d;
      rowcount_q   <= rowcount_d;
      colcount_q   <= colcount_d;
      line_end_q   <= line_end_d;
      frame_end_q  <= frame_end_d;
      mode_err_q   <= mode_err_d;
    end
  end

  assign bus.pass_valid  = pass_valid_q;
  assign bus.rowcount    = rowcount_q;
  assign bus.colcount    = colcount_q;
  assign bus.line_end    = line_end_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.mode_active = mode_q;
  assign bus.sel_bypass  = (mode_q == 2'd0);
  assign bus.sel_window  = (mode_q == 2'd2);
  assign bus.path_reset  = (state_q == ST_DRAIN);
  assign bus.busy        = (state_q != ST_RUN);
  assign bus.mode_err    = mode_err_q;

endmodule

// File: tb/tb_frame_path_sequencer.sv
// Randomized bench for frame_path_sequencer with a frame-level reference model
// and a few directed scenarios pinned by hand-computed values.
module tb_frame_path_sequencer;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DC = 3;

  logic clock;
  logic reset;
  frame_path_sequencer_if bus();

  frame_path_sequencer #(.WIDTH(W), .HEIGHT(H), .DRAIN_CYCLES(DC), .MODE_RESET(0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: linear pixel index within the frame, mode, optional
  // pending request, remaining flush cycles and a wait-for-frame flag.
  int pos = 0, mode = 0, pend_val = 0, drain_left = 0;
  bit pend = 0, wait_sync = 0, model_live = 0;
  int e_pass, e_row, e_col, e_le, e_fe, e_err, e_mode, e_busy, e_preset;

  always @(posedge clock) begin
    bit blanked, wrap, legal;
    if (reset) begin
      pos = 0; mode = 0; pend = 0; pend_val = 0; drain_left = 0; wait_sync = 0;
      e_pass = 0; e_row = 0; e_col = 0; e_le = 0; e_fe = 0; e_err = 0;
    end else begin
      blanked = (drain_left > 0) || wait_sync;
      wrap    = bus.valid && (pos == W*H - 1);
      legal   = bus.mode_req_en && (bus.mode_req != 2'd3);
      e_pass  = int'(bus.valid && !blanked);
      e_row   = pos / W;
      e_col   = pos % W;
      e_le    = int'(bus.valid && ((pos % W) == W - 1));
      e_fe    = int'(wrap);
      e_err   = int'(bus.mode_req_en && (bus.mode_req == 2'd3));
      if (drain_left > 0) begin
        drain_left--;
        if (drain_left == 0) wait_sync = 1;
      end else if (wait_sync) begin
        if (wrap) wait_sync = 0;
      end else if (pend) begin
        if (legal && int'(bus.mode_req) == mode) begin
          pend = 0;
        end else begin
          if (legal) pend_val = int'(bus.mode_req);
          if (wrap) begin
            mode = pend_val; pend = 0; drain_left = DC;
          end
        end
      end else if (legal && int'(bus.mode_req) != mode) begin
        pend = 1; pend_val = int'(bus.mode_req);
      end
      if (bus.valid) pos = (pos + 1) % (W*H);
    end
    e_mode     = mode;
    e_busy     = int'(pend || (drain_left > 0) || wait_sync);
    e_preset   = int'(drain_left > 0);
    model_live = 1;
  end

  int n_pass = 0, n_le = 0, n_fe = 0, n_preset = 0;

  always @(negedge clock) begin
    if (model_live) begin
      chk("pass_valid", int'(bus.pass_valid), e_pass);
      chk("line_end", int'(bus.line_end), e_le);
      chk("frame_end", int'(bus.frame_end), e_fe);
      chk("mode_err", int'(bus.mode_err), e_err);
      chk("mode_active", int'(bus.mode_active), e_mode);
      chk("sel_bypass", int'(bus.sel_bypass), int'(e_mode == 0));
      chk("sel_window", int'(bus.sel_window), int'(e_mode == 2));
      chk("busy", int'(bus.busy), e_busy);
      chk("path_reset", int'(bus.path_reset), e_preset);
      if (e_pass == 1 && bus.pass_valid) begin
        chk("rowcount", int'(bus.rowcount), e_row);
        chk("colcount", int'(bus.colcount), e_col);
      end
      if (bus.pass_valid) n_pass++;
      if (bus.line_end)   n_le++;
      if (bus.frame_end)  n_fe++;
      if (bus.path_reset) n_preset++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #3;
  endtask

  initial begin
    int s_pass, s_le, s_fe, s_pr;
    bit seen;
    reset = 1'b1;
    bus.valid = 1'b0; bus.mode_req = 2'd0; bus.mode_req_en = 1'b0;
    repeat (2) tick();
    chk("reset_pass_valid", int'(bus.pass_valid), 0);
    chk("reset_sel_bypass", int'(bus.sel_bypass), 1);
    reset = 1'b0;

    // One full frame in bypass mode.
    s_pass = n_pass; s_le = n_le; s_fe = n_fe;
    bus.valid = 1'b1;
    repeat (12) tick();
    bus.valid = 1'b0;
    repeat (3) tick();
    chk("frame0_pass_count", n_pass - s_pass, 12);
    chk("frame0_line_end_count", n_le - s_le, 3);
    chk("frame0_frame_end_count", n_fe - s_fe, 1);

    // Request full window at pixel (0,1).
    bus.valid = 1'b1;
    tick();
    bus.mode_req = 2'd2; bus.mode_req_en = 1'b1;
    tick();
    bus.mode_req_en = 1'b0;
    chk("req_busy", int'(bus.busy), 1);
    s_pr = n_preset;
    repeat (10) tick();
    repeat (20) tick();
    chk("drain_cycles", n_preset - s_pr, 3);
    chk("switched_mode", int'(bus.mode_active), 2);
    chk("switched_sel_window", int'(bus.sel_window), 1);

    // Illegal request.
    bus.mode_req = 2'd3; bus.mode_req_en = 1'b1;
    tick();
    bus.mode_req_en = 1'b0;
    chk("illegal_err", int'(bus.mode_err), 1);
    chk("illegal_busy", int'(bus.busy), 0);
    tick();
    chk("illegal_err_clear", int'(bus.mode_err), 0);

    // Reset in the middle of a drain.
    bus.mode_req = 2'd1; bus.mode_req_en = 1'b1;
    tick();
    bus.mode_req_en = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.path_reset) seen = 1;
    end
    chk("drain_reached", int'(seen), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_drain_path_reset", int'(bus.path_reset), 0);
    chk("rst_drain_busy", int'(bus.busy), 0);
    chk("rst_drain_mode", int'(bus.mode_active), 0);

    // Half-rate valid for one frame.
    s_fe = n_fe;
    for (int i = 0; i < 24; i++) begin
      bus.valid = (i % 2 == 0);
      tick();
    end
    bus.valid = 1'b0;
    repeat (2) tick();
    chk("halfrate_frame_end", n_fe - s_fe, 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      reset           = ($urandom_range(0, 299) == 0);
      bus.valid       = ($urandom_range(0, 99) < 75);
      bus.mode_req_en = ($urandom_range(0, 7) == 0);
      bus.mode_req    = 2'($urandom_range(0, 3));
      tick();
    end
    reset = 1'b0; bus.valid = 1'b0; bus.mode_req_en = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
